id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

Parametrised ID/EX pipeline stage for the NPC pipeline. It holds one decoded instruction between decode and execute, using valid/ready handshakes on both sides. It supports flush, load-use bubble insertion, register-file write-back bypass into the captured and held operands, and saturating performance counters for stalls, bubbles and flushes. It replaces the fixed 64-bit decode-output register with a width- and bundle-generic stage that can stall.

## Interface
Parameters:
- XLEN, 64, operand/PC/immediate width
- CTRL_W, 24, width of the opaque ALU/branch/load/store/wb control bundle (passed through untouched)
- FX_W, 5, width of side-effect enables {jump, branch, load, store, wb}; cleared on bubble/flush
- BYPASS, 1, 1 = forward write-back data into rs1/rs2 operands; 0 = no forwarding
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts this cycle (combinational)
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_ctrl  in  CTRL_W  control bundle
- in_fx  in  FX_W  side-effect enables
- out_valid  out  1  stage holds a live instruction
- out_ready  in  1  execute accepts
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  registered fields
- out_rs1, out_rs2, out_rd  out  5  registered indices
- out_ctrl  out  CTRL_W  registered control
- out_fx  out  FX_W  registered side-effect enables, all-zero whenever out_valid=0
- flush  in  1  kill held and incoming instruction (branch/jump redirect)
- hz_bubble  in  1  load-use hazard: hold decode, send bubble
- wb_en  in  1  write-back valid
- wb_rd  in  5  write-back index
- wb_data  in  XLEN  write-back data
- cnt_clr  in  1  synchronous clear of all counters
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Define `adv = !out_valid | out_ready`, meaning the stage can load this cycle.
- in_ready = flush | (!hz_bubble & adv).
- Priority, highest first:
  - rst.
  - flush: out_valid<=0 and out_fx<=0. The incoming instruction is consumed and discarded.
  - hz_bubble & adv: out_valid<=0 and out_fx<=0. Decode is not consumed.
  - in_valid & adv: load all fields and set out_valid<=1.
  - !in_valid & adv: out_valid<=0 and out_fx<=0.
  - Otherwise: hold.
- Bubble/flush leave pc, indices, data, imm and ctrl at their previous values. Execute must qualify on out_valid / out_fx.
- Bypass on capture (BYPASS=1): rsN_data = (wb_en & wb_rd==in_rsN & in_rsN!=0) ? wb_data : in_rsN_data.
- Bypass on hold (BYPASS=1): while out_valid & !out_ready, if wb_en & wb_rd==out_rsN & out_rsN!=0, update out_rsN_data<=wb_data. Both operands update independently.
- x0 is never forwarded.
- Counters, each saturating at all-ones:
  - stall_cnt +1 per cycle with out_valid & !out_ready & !flush.
  - bubble_cnt +1 per cycle with hz_bubble & adv & !flush.
  - flush_cnt +1 per cycle with flush.
- cnt_clr zeroes all counters and takes priority over increments.

## Timing
- Reset: out_valid=0, out_fx=0, and every other registered output is 0, counters included. in_ready = !hz_bubble after reset.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction per cycle when out_ready=1.
- in_ready is a combinational function of flush, hz_bubble, out_valid and out_ready. There is no path from in_valid to in_ready.
- out_* are registered only. There is no combinational input-to-output path.
- Handshake: while out_valid=1 & out_ready=0, every out_* is stable except bypass updates of rs1/rs2 data.
- Simultaneous flush & hz_bubble: flush wins. Only flush_cnt increments.
- Simultaneous wb to rs1 and rs2 with the same index: both operands take wb_data.
- rst mid-stall: the instruction is dropped and counters are zeroed.

## Test plan
- Reset, then stream pc=0x80000000, +4, +8 with out_ready=1 -> out_valid high from cycle 1, out_pc matches each input one cycle later, in_ready constant 1.
- Hold out_ready=0 for 3 cycles with an instruction held -> in_ready=0, out_* stable, stall_cnt=3; release -> next instruction accepted the same cycle.
- hz_bubble=1 for 1 cycle with in_fx=5'b11111 pending -> out_valid=0, out_fx=0, in_ready=0, bubble_cnt=1; next cycle the same instruction is captured with out_fx=5'b11111.
- Capture in_rs1=5 with in_rs1_data=0x11 while wb_en=1, wb_rd=5, wb_data=0xAB -> out_rs1_data=0xAB. Repeat with wb_rd=0 and in_rs1=0 -> no forward. Repeat with BYPASS=0 -> 0x11.
- Held instruction (out_ready=0) with out_rs2=7, then wb_en=1, wb_rd=7, wb_data=0xCAFE -> out_rs2_data=0xCAFE next cycle, out_rs1_data unchanged.
- flush and hz_bubble together while stalled -> out_valid=0 next cycle, in_ready=1, flush_cnt+1, bubble_cnt and stall_cnt unchanged. Preload a counter to all-ones via a long stall with CNT_W=4 -> stall_cnt holds at 15.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: holds one decoded instruction between decode and execute,
// with flush, load-use bubbles, write-back bypass and saturating perf counters.
module id_ex_pipe #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned FX_W   = 5,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [FX_W-1:0]   in_fx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [FX_W-1:0]   out_fx,
  input  logic              flush,
  input  logic              hz_bubble,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned REG_W   = 5;
  localparam bit          USE_BYP = (BYPASS != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_W-1:0]  r_rs1;
  logic [REG_W-1:0]  r_rs2;
  logic [REG_W-1:0]  r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic [FX_W-1:0]   r_fx;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_adv;
  logic              w_load;
  logic              w_drop;
  logic [XLEN-1:0]   w_cap_rs1;
  logic [XLEN-1:0]   w_cap_rs2;
  logic              w_hold_fwd1;
  logic              w_hold_fwd2;
  logic              w_stall_inc;
  logic              w_bubble_inc;

  // Handshake decode; flush always consumes decode, a bubble never does.
  always_comb begin
    w_adv    = !r_valid || out_ready;
    in_ready = flush || (!hz_bubble && w_adv);
    w_load   = !flush && !hz_bubble && in_valid && w_adv;
    w_drop   = flush || (w_adv && !w_load);
  end

  // Write-back forwarding into capture and held operands; x0 is never forwarded.
  always_comb begin
    w_cap_rs1   = in_rs1_data;
    w_cap_rs2   = in_rs2_data;
    w_hold_fwd1 = 1'b0;
    w_hold_fwd2 = 1'b0;
    if (USE_BYP) begin
      if (wb_en && (wb_rd == in_rs1) && (in_rs1 != REG_W'(0))) w_cap_rs1 = wb_data;
      if (wb_en && (wb_rd == in_rs2) && (in_rs2 != REG_W'(0))) w_cap_rs2 = wb_data;
      w_hold_fwd1 = wb_en && (wb_rd == r_rs1) && (r_rs1 != REG_W'(0));
      w_hold_fwd2 = wb_en && (wb_rd == r_rs2) && (r_rs2 != REG_W'(0));
    end
  end

  always_comb begin
    w_stall_inc  = r_valid && !out_ready && !flush;
    w_bubble_inc = hz_bubble && w_adv && !flush;
  end

  // Instruction register: load, drop (bubble/flush/empty) or hold with bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_fx       <= '0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_pc       <= in_pc;
      r_rs1_data <= w_cap_rs1;
      r_rs2_data <= w_cap_rs2;
      r_imm      <= in_imm;
      r_rs1      <= in_rs1;
      r_rs2      <= in_rs2;
      r_rd       <= in_rd;
      r_ctrl     <= in_ctrl;
      r_fx       <= in_fx;
    end else if (w_drop) begin
      r_valid <= 1'b0;
      r_fx    <= '0;
    end else begin
      if (w_hold_fwd1) r_rs1_data <= wb_data;
      if (w_hold_fwd2) r_rs2_data <= wb_data;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX))   r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
      if (w_bubble_inc && (r_bubble_cnt != CNT_MAX)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (flush && (r_flush_cnt != CNT_MAX))         r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_rs1_data = r_rs1_data;
  assign out_rs2_data = r_rs2_data;
  assign out_imm      = r_imm;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_ctrl     = r_ctrl;
  assign out_fx       = r_fx;
  assign stall_cnt    = r_stall_cnt;
  assign bubble_cnt   = r_bubble_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: two instances (bypass/32-bit counters, no bypass/4-bit
// counters) share stimulus and are checked every cycle against a reference model.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush, hz_bubble, wb_en, cnt_clr;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm, wb_data;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd, in_fx;
  logic [23:0] in_ctrl;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [63:0] a_out_pc, a_out_rs1_data, a_out_rs2_data, a_out_imm;
  logic [63:0] b_out_pc, b_out_rs1_data, b_out_rs2_data, b_out_imm;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd, a_out_fx;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd, b_out_fx;
  logic [23:0] a_out_ctrl, b_out_ctrl;
  logic [31:0] a_stall_cnt, a_bubble_cnt, a_flush_cnt;
  logic [3:0]  b_stall_cnt, b_bubble_cnt, b_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.XLEN(64), .CTRL_W(24), .FX_W(5), .BYPASS(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_fx(in_fx),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_rs1_data(a_out_rs1_data), .out_rs2_data(a_out_rs2_data), .out_imm(a_out_imm),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd), .out_ctrl(a_out_ctrl),
    .out_fx(a_out_fx), .flush(flush), .hz_bubble(hz_bubble), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .cnt_clr(cnt_clr), .stall_cnt(a_stall_cnt),
    .bubble_cnt(a_bubble_cnt), .flush_cnt(a_flush_cnt));

  id_ex_pipe #(.XLEN(64), .CTRL_W(24), .FX_W(5), .BYPASS(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_fx(in_fx),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_rs1_data(b_out_rs1_data), .out_rs2_data(b_out_rs2_data), .out_imm(b_out_imm),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_ctrl(b_out_ctrl),
    .out_fx(b_out_fx), .flush(flush), .hz_bubble(hz_bubble), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .cnt_clr(cnt_clr), .stall_cnt(b_stall_cnt),
    .bubble_cnt(b_bubble_cnt), .flush_cnt(b_flush_cnt));

  typedef struct {
    logic        v;
    logic [63:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd, fx;
    logic [23:0] ctrl;
    logic [31:0] sc, bc, fc;
  } mdl_t;

  mdl_t ma, mb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] fwd(input bit byp, input logic [4:0] idx, input logic [63:0] rf);
    if (byp && wb_en && wb_rd == idx && idx != 5'd0) return wb_data;
    return rf;
  endfunction

  function automatic logic exp_rdy(input mdl_t s);
    return flush || (!hz_bubble && (!s.v || out_ready));
  endfunction

  // One clock of the stage as described by the handshake/priority rules.
  function automatic mdl_t mstep(input mdl_t s, input bit byp, input logic [31:0] cmax);
    mdl_t n;
    bit   can_load;
    n = s;
    can_load = !s.v || out_ready;
    if (rst) begin
      n = '{default: '0};
      return n;
    end
    if (cnt_clr) begin
      n.sc = 0; n.bc = 0; n.fc = 0;
    end else begin
      if (s.v && !out_ready && !flush && s.sc != cmax) n.sc = s.sc + 1;
      if (hz_bubble && can_load && !flush && s.bc != cmax) n.bc = s.bc + 1;
      if (flush && s.fc != cmax) n.fc = s.fc + 1;
    end
    if (flush || (can_load && (hz_bubble || !in_valid))) begin
      n.v = 1'b0; n.fx = '0;
    end else if (can_load) begin
      n.v = 1'b1; n.pc = in_pc; n.imm = in_imm; n.ctrl = in_ctrl; n.fx = in_fx;
      n.rs1 = in_rs1; n.rs2 = in_rs2; n.rd = in_rd;
      n.d1 = fwd(byp, in_rs1, in_rs1_data);
      n.d2 = fwd(byp, in_rs2, in_rs2_data);
    end else begin
      n.d1 = fwd(byp, s.rs1, s.d1);
      n.d2 = fwd(byp, s.rs2, s.d2);
    end
    return n;
  endfunction

  task automatic cmp(input string p, input mdl_t m, input logic v, input logic [63:0] pc,
                     input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic [23:0] ctrl, input logic [4:0] fx, input logic [31:0] sc,
                     input logic [31:0] bc, input logic [31:0] fc);
    check_eq({p, "out_valid"}, 64'(v), 64'(m.v));
    check_eq({p, "out_pc"}, pc, m.pc);
    check_eq({p, "out_rs1_data"}, d1, m.d1);
    check_eq({p, "out_rs2_data"}, d2, m.d2);
    check_eq({p, "out_imm"}, imm, m.imm);
    check_eq({p, "out_idx"}, 64'({r1, r2, rd}), 64'({m.rs1, m.rs2, m.rd}));
    check_eq({p, "out_ctrl"}, 64'(ctrl), 64'(m.ctrl));
    check_eq({p, "out_fx"}, 64'(fx), 64'(m.fx));
    check_eq({p, "stall_cnt"}, 64'(sc), 64'(m.sc));
    check_eq({p, "bubble_cnt"}, 64'(bc), 64'(m.bc));
    check_eq({p, "flush_cnt"}, 64'(fc), 64'(m.fc));
  endtask

  // Inputs are already applied; check in_ready mid-cycle, clock, then check outputs.
  task automatic step();
    mdl_t na, nb;
    @(negedge clk);
    check_eq("a_in_ready", 64'(a_in_ready), 64'(exp_rdy(ma)));
    check_eq("b_in_ready", 64'(b_in_ready), 64'(exp_rdy(mb)));
    na = mstep(ma, 1'b1, 32'hFFFF_FFFF);
    nb = mstep(mb, 1'b0, 32'd15);
    @(posedge clk);
    ma = na;
    mb = nb;
    #1;
    cmp("a_", ma, a_out_valid, a_out_pc, a_out_rs1_data, a_out_rs2_data, a_out_imm,
        a_out_rs1, a_out_rs2, a_out_rd, a_out_ctrl, a_out_fx, a_stall_cnt, a_bubble_cnt,
        a_flush_cnt);
    cmp("b_", mb, b_out_valid, b_out_pc, b_out_rs1_data, b_out_rs2_data, b_out_imm,
        b_out_rs1, b_out_rs2, b_out_rd, b_out_ctrl, b_out_fx, 32'(b_stall_cnt),
        32'(b_bubble_cnt), 32'(b_flush_cnt));
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; out_ready = 1; flush = 0; hz_bubble = 0; wb_en = 0; cnt_clr = 0;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_ctrl = '0; in_fx = '0; wb_rd = '0; wb_data = '0;
  endtask

  initial begin
    logic [31:0] sc0, bc0, fc0;
    ma = '{default: '0};
    mb = '{default: '0};
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    check_eq("rst_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_pc", a_out_pc, 64'd0);

    // Back-to-back stream.
    in_valid = 1; in_fx = 5'h3; in_pc = 64'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stream_pc", a_out_pc, 64'h8000_0000 + 64'(4 * i));
      check_eq("stream_rdy", 64'(a_in_ready), 64'd1);
      in_pc = in_pc + 64'd4;
    end

    // Three-cycle stall, then release.
    out_ready = 0;
    for (int i = 0; i < 3; i++) step();
    check_eq("stall_cnt3", 64'(a_stall_cnt), 64'd3);
    check_eq("stall_hold_pc", a_out_pc, 64'h8000_0008);
    check_eq("stall_in_ready", 64'(a_in_ready), 64'd0);
    out_ready = 1;
    step();
    check_eq("release_pc", a_out_pc, 64'h8000_000C);

    // Load-use bubble, then the same instruction is captured.
    in_fx = 5'h1F; in_pc = 64'h8000_0010; hz_bubble = 1;
    step();
    check_eq("bubble_valid", 64'(a_out_valid), 64'd0);
    check_eq("bubble_fx", 64'(a_out_fx), 64'd0);
    check_eq("bubble_cnt1", 64'(a_bubble_cnt), 64'd1);
    hz_bubble = 0;
    step();
    check_eq("after_bubble_fx", 64'(a_out_fx), 64'h1F);

    // Capture-time bypass, x0 exclusion, and no-bypass variant.
    in_rs1 = 5; in_rs1_data = 64'h11; wb_en = 1; wb_rd = 5; wb_data = 64'hAB;
    step();
    check_eq("cap_fwd", a_out_rs1_data, 64'hAB);
    check_eq("cap_nobyp", b_out_rs1_data, 64'h11);
    in_rs1 = 0; wb_rd = 0;
    step();
    check_eq("cap_x0", a_out_rs1_data, 64'h11);

    // Hold-time bypass on rs2 only.
    in_rs1 = 3; in_rs1_data = 64'h33; in_rs2 = 7; in_rs2_data = 64'h77; wb_en = 0;
    step();
    out_ready = 0; wb_en = 1; wb_rd = 7; wb_data = 64'hCAFE;
    step();
    check_eq("hold_fwd_rs2", a_out_rs2_data, 64'hCAFE);
    check_eq("hold_keep_rs1", a_out_rs1_data, 64'h33);
    check_eq("hold_nobyp_rs2", b_out_rs2_data, 64'h77);

    // Flush and bubble together while stalled: only flush is counted.
    wb_en = 0;
    sc0 = a_stall_cnt; bc0 = a_bubble_cnt; fc0 = a_flush_cnt;
    flush = 1; hz_bubble = 1;
    step();
    check_eq("flush_valid", 64'(a_out_valid), 64'd0);
    check_eq("flush_cnt_inc", 64'(a_flush_cnt), 64'(fc0 + 1));
    check_eq("flush_bub_same", 64'(a_bubble_cnt), 64'(bc0));
    check_eq("flush_stall_same", 64'(a_stall_cnt), 64'(sc0));
    flush = 0; hz_bubble = 0;

    // Long stall saturates the 4-bit counter.
    out_ready = 1;
    step();
    out_ready = 0;
    for (int i = 0; i < 20; i++) step();
    check_eq("sat_stall_b", 64'(b_stall_cnt), 64'd15);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 255) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 15) == 0);
      hz_bubble   = ($urandom_range(0, 7) == 0);
      cnt_clr     = ($urandom_range(0, 63) == 0);
      wb_en       = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 3));
      wb_data     = {$urandom, $urandom};
      in_pc       = {$urandom, $urandom};
      in_imm      = {$urandom, $urandom};
      in_rs1_data = {$urandom, $urandom};
      in_rs2_data = {$urandom, $urandom};
      in_rs1      = 5'($urandom_range(0, 3));
      in_rs2      = 5'($urandom_range(0, 3));
      in_rd       = 5'($urandom);
      in_ctrl     = 24'($urandom);
      in_fx       = 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
